imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, instruction width.
REQ-003 SHALL have parameter MEM_DEPTH, default 32, number of populated ROM words; power of two and at most 2^ADDR_W.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after start.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  begin fetching from IDLE or HALTED.
- imem_addr  output  ADDR_W  address driven to combinational instruction ROM.
- imem_data  input  DATA_W  ROM read data; valid in the same cycle as imem_addr.
- instr  output  DATA_W  registered instruction to decoder.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decoder accepts instr.
- redirect  input  1  branch/jump: discard instr, refetch from redirect_addr.
- redirect_addr  input  ADDR_W  branch target.
- halt_req  input  1  stop fetching.
- running  output  1  high in FETCH or VALID.

Function
REQ-007 SHALL implement states IDLE, FETCH, VALID, HALTED; encoding free.
REQ-008 imem_addr SHALL equal the internal fetch_pc register in every state.
REQ-009 IDLE: start=1 -> fetch_pc<=RESET_PC, go FETCH; else stay.
REQ-010 FETCH: instr<=imem_data, instr_pc<=fetch_pc, fetch_pc<=next(fetch_pc), go VALID; start to first instr_valid = 2 cycles.
REQ-011 VALID: instr_valid=1; instr and instr_pc SHALL stay stable while instr_ready=0.
REQ-012 VALID with instr_ready=1 (handshake): load next word (instr<=imem_data, instr_pc<=fetch_pc, fetch_pc<=next); stay VALID; sustained throughput one instruction per cycle.
REQ-013 next(a) SHALL be (a+1) mod MEM_DEPTH; MEM_DEPTH-1 wraps to 0.
REQ-014 redirect=1 in FETCH or VALID: fetch_pc<=redirect_addr mod MEM_DEPTH, go FETCH, instr_valid=0 next cycle; a simultaneous handshake still counts as accepted but no further word loads.
REQ-015 halt_req=1 in FETCH or VALID SHALL take priority over redirect and handshake: go HALTED, instr_valid=0 next cycle.
REQ-016 HALTED: fetch_pc held; start=1 -> fetch_pc<=RESET_PC, go FETCH.
REQ-017 redirect and halt_req SHALL be ignored in IDLE and HALTED; start ignored in FETCH and VALID.
REQ-018 instr_valid SHALL be high only in VALID.

Reset
REQ-019 reset=1 SHALL, at the next clock edge, force IDLE, fetch_pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, running=0, overriding all other inputs.
REQ-020 Reset asserted mid-stream SHALL drop any held instruction with no further handshake.

Configuration
REQ-021 Macro IMEM_FETCH_COUNT_EN defined: extra output fetch_count (16 bits), cleared by reset, +1 per handshake, saturating at 16'hFFFF, not cleared by start.
REQ-022 Macro IMEM_FETCH_COUNT_EN undefined: fetch_count port and logic absent; all other behaviour identical.

Verification
REQ-023 Reset, start=1 for one cycle, instr_ready=1 -> instr_valid high from 2 cycles after start; instr_pc 0,1,2,... one per cycle; instr equals ROM word at instr_pc.
REQ-024 instr_ready=0 for 3 cycles at instr_pc=4 -> instr and instr_pc=4 stable; on release, next cycle instr_pc=5.
REQ-025 Stream to instr_pc=31 with MEM_DEPTH=32 -> next instr_pc=0.
REQ-026 redirect=1, redirect_addr=8'd40 in VALID -> instr_valid=0 one cycle; next instr_pc=8 (40 mod 32).
REQ-027 halt_req=1 with redirect=1 in VALID -> HALTED, instr_valid=0, running=0; start=1 later -> instr_pc restarts at RESET_PC.
REQ-028 With IMEM_FETCH_COUNT_EN: 10 handshakes -> fetch_count=10; reset -> fetch_count=0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch controller for a combinational instruction ROM.
// It walks fetch_pc through the ROM and presents one registered instruction at a time to
// the decoder using a valid/ready handshake. It also handles branch redirects, halt
// requests and restart.
// Optional feature: define IMEM_FETCH_COUNT_EN to add a saturating 16-bit fetch_count
// output that counts accepted instructions.
module imem_fetch_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 32,
   parameter int RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              halt_req,
   output logic              running
`ifdef IMEM_FETCH_COUNT_EN
   ,
   output logic [15:0]       fetch_count
`endif
);

   // MEM_DEPTH is a power of two, so "mod MEM_DEPTH" is a mask of the low address bits.
   localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC) & PC_MASK;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_VALID  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_pc;

   // Sequential ROM address with wrap at the top of the populated range.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
      return (a + ADDR_W'(1)) & PC_MASK;
   endfunction

   assign imem_addr = fetch_pc;

   // Fetch FSM. Priority in the active states is halt, then redirect, then the word load.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         fetch_pc    <= START_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         running     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  fetch_pc <= START_PC;
                  state    <= S_FETCH;
                  running  <= 1'b1;
               end
            end
            S_FETCH: begin
               if (halt_req) begin
                  state       <= S_HALTED;
                  instr_valid <= 1'b0;
                  running     <= 1'b0;
               end else if (redirect) begin
                  fetch_pc    <= redirect_addr & PC_MASK;
                  instr_valid <= 1'b0;
               end else begin
                  instr       <= imem_data;
                  instr_pc    <= fetch_pc;
                  fetch_pc    <= next_pc(fetch_pc);
                  state       <= S_VALID;
                  instr_valid <= 1'b1;
               end
            end
            S_VALID: begin
               if (halt_req) begin
                  state       <= S_HALTED;
                  instr_valid <= 1'b0;
                  running     <= 1'b0;
               end else if (redirect) begin
                  // The word in flight is discarded; a coincident handshake is still
                  // accepted by the decoder but nothing new is loaded.
                  fetch_pc    <= redirect_addr & PC_MASK;
                  state       <= S_FETCH;
                  instr_valid <= 1'b0;
               end else if (instr_ready) begin
                  instr    <= imem_data;
                  instr_pc <= fetch_pc;
                  fetch_pc <= next_pc(fetch_pc);
               end
            end
            default: begin
               state       <= S_IDLE;
               instr_valid <= 1'b0;
               running     <= 1'b0;
            end
         endcase
      end
   end

`ifdef IMEM_FETCH_COUNT_EN
   logic handshake;
   assign handshake = (state == S_VALID) && instr_ready && !halt_req;

   // Accepted-instruction counter, saturating; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (handshake && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a 32-word combinational ROM model.
module tb_imem_fetch_ctrl;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              halt_req;
   logic              running;
`ifdef IMEM_FETCH_COUNT_EN
   logic [15:0]       fetch_count;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(32), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_addr(redirect_addr), .halt_req(halt_req), .running(running)
`ifdef IMEM_FETCH_COUNT_EN
      , .fetch_count(fetch_count)
`endif
   );

   always #5 clk = ~clk;

   // ROM contents: word at address a is a*13+5 (8-bit), out-of-range reads return 0.
   function automatic logic [7:0] word(input logic [7:0] a);
      return 8'(a * 13 + 5);
   endfunction

   assign imem_data = (imem_addr < 8'd32) ? word(imem_addr) : 8'h00;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; instr_ready = 1'b1; redirect = 1'b1;
      redirect_addr = 8'd7; halt_req = 1'b0;
      tick();
      tick();
      reset = 1'b0; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
      tests_run++;
      if (running !== 1'b0) begin tests_failed++; $display("FAIL reset_running got %0b exp 0", running); end
      tests_run++;
      if (imem_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", imem_addr); end
      tests_run++;
      if (instr !== 8'd0 || instr_pc !== 8'd0) begin
         tests_failed++; $display("FAIL reset_instr got %0h/%0d exp 0/0", instr, instr_pc);
      end
      // Idle ignores redirect and halt
      redirect = 1'b1; halt_req = 1'b1; redirect_addr = 8'd9;
      tick();
      redirect = 1'b0; halt_req = 1'b0;
      tests_run++;
      if (running !== 1'b0 || imem_addr !== 8'd0) begin
         tests_failed++; $display("FAIL idle_ignore got run=%0b addr=%0d exp 0/0", running, imem_addr);
      end
   endtask

   task automatic test_stream();
      start = 1'b1; instr_ready = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0 || running !== 1'b1 || imem_addr !== 8'd0) begin
         tests_failed++;
         $display("FAIL fetch_state got v=%0b r=%0b a=%0d exp 0/1/0", instr_valid, running, imem_addr);
      end
      tick();
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'd0 || instr !== 8'h05) begin
         tests_failed++;
         $display("FAIL first_instr got v=%0b pc=%0d i=%0h exp 1/0/05", instr_valid, instr_pc, instr);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests_run++;
         if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr !== word(8'(i))) begin
            tests_failed++;
            $display("FAIL stream_%0d got v=%0b pc=%0d i=%0h exp 1/%0d/%0h",
                     i, instr_valid, instr_pc, instr, i, word(8'(i)));
         end
      end
      // start is ignored while running: next word continues at 4
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (instr_pc !== 8'd4 || instr !== 8'h39) begin
         tests_failed++; $display("FAIL start_ignored got pc=%0d i=%0h exp 4/39", instr_pc, instr);
      end
   endtask

   task automatic test_stall();
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (instr_valid !== 1'b1 || instr_pc !== 8'd4 || instr !== 8'h39) begin
            tests_failed++;
            $display("FAIL stall_%0d got v=%0b pc=%0d i=%0h exp 1/4/39", i, instr_valid, instr_pc, instr);
         end
      end
      instr_ready = 1'b1;
      tick();
      tests_run++;
      if (instr_pc !== 8'd5 || instr !== 8'h46) begin
         tests_failed++; $display("FAIL stall_release got pc=%0d i=%0h exp 5/46", instr_pc, instr);
      end
   endtask

   task automatic test_wrap();
      int n;
      n = 0;
      while (instr_pc !== 8'd31 && n < 40) begin
         tick();
         n++;
      end
      tests_run++;
      if (instr_pc !== 8'd31 || instr !== 8'h98) begin
         tests_failed++; $display("FAIL wrap_reach got pc=%0d i=%0h exp 31/98", instr_pc, instr);
      end
      tick();
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'd0 || instr !== 8'h05) begin
         tests_failed++;
         $display("FAIL wrap_zero got v=%0b pc=%0d i=%0h exp 1/0/05", instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_addr = 8'd40;
      tick();
      redirect = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0 || imem_addr !== 8'd8 || running !== 1'b1) begin
         tests_failed++;
         $display("FAIL redirect_bubble got v=%0b a=%0d r=%0b exp 0/8/1", instr_valid, imem_addr, running);
      end
      tick();
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'd8 || instr !== 8'h6D) begin
         tests_failed++;
         $display("FAIL redirect_target got v=%0b pc=%0d i=%0h exp 1/8/6d", instr_valid, instr_pc, instr);
      end
      tick();
      tests_run++;
      if (instr_pc !== 8'd9) begin
         tests_failed++; $display("FAIL redirect_next got pc=%0d exp 9", instr_pc);
      end
   endtask

   task automatic test_halt();
      halt_req = 1'b1; redirect = 1'b1; redirect_addr = 8'd3;
      tick();
      halt_req = 1'b0; redirect = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0 || running !== 1'b0 || imem_addr !== 8'd10) begin
         tests_failed++;
         $display("FAIL halt got v=%0b r=%0b a=%0d exp 0/0/10", instr_valid, running, imem_addr);
      end
      redirect = 1'b1; redirect_addr = 8'd2;
      tick();
      tick();
      redirect = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0 || running !== 1'b0 || imem_addr !== 8'd10) begin
         tests_failed++;
         $display("FAIL halted_hold got v=%0b r=%0b a=%0d exp 0/0/10", instr_valid, running, imem_addr);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'd0 || instr !== 8'h05 || running !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart got v=%0b pc=%0d i=%0h r=%0b exp 1/0/05/1",
                  instr_valid, instr_pc, instr, running);
      end
   endtask

   task automatic test_mid_reset();
      instr_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; instr_ready = 1'b1;
      tests_run++;
      if (instr_valid !== 1'b0 || running !== 1'b0 || instr !== 8'd0 || instr_pc !== 8'd0) begin
         tests_failed++;
         $display("FAIL mid_reset got v=%0b r=%0b i=%0h pc=%0d exp 0/0/0/0",
                  instr_valid, running, instr, instr_pc);
      end
      tick();
      tick();
      tests_run++;
      if (instr_valid !== 1'b0 || imem_addr !== 8'd0) begin
         tests_failed++; $display("FAIL mid_reset_idle got v=%0b a=%0d exp 0/0", instr_valid, imem_addr);
      end
   endtask

`ifdef IMEM_FETCH_COUNT_EN
   task automatic test_count();
      reset = 1'b1;
      tick();
      reset = 1'b0; start = 1'b1; instr_ready = 1'b0;
      tick();
      start = 1'b0;
      tick();
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      instr_ready = 1'b0;
      tick();
      tests_run++;
      if (fetch_count !== 16'd10) begin
         tests_failed++; $display("FAIL count_10 got %0d exp 10", fetch_count);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (fetch_count !== 16'd0) begin
         tests_failed++; $display("FAIL count_reset got %0d exp 0", fetch_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_redirect();
      test_halt();
      test_mid_reset();
`ifdef IMEM_FETCH_COUNT_EN
      test_count();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
